// File: rtl/rc5_pkg.sv
// Shared RC5 encryptor definitions: default geometry and FSM state encoding.
package rc5_pkg;

    localparam int RC5_W        = 32;
    localparam int RC5_R        = 12;
    localparam int RC5_T        = 2 * (RC5_R + 1);
    localparam int RC5_W_BITS   = $clog2(RC5_W);
    localparam int RC5_T_LENGTH = $clog2(RC5_T);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE_A = 3'd1,
        PRE_B = 3'd2,
        RND_A = 3'd3,
        RND_B = 3'd4,
        DONE  = 3'd5
    } rc5_state_t;

endpackage

// File: rtl/rc5_rotl.sv
// Combinational left-circular rotate of a W-bit word by the low W_BITS of an amount.
module rc5_rotl #(
    parameter int W      = 32,
    parameter int W_BITS = $clog2(W)
) (
    input  logic [W-1:0]      word,
    input  logic [W_BITS-1:0] amount,
    output logic [W-1:0]      rotated
);

    logic [W_BITS-1:0] back;

    // W - amount wraps to zero for amount 0, so both shifts then return the word unchanged
    assign back    = W_BITS'(0) - amount;
    assign rotated = (word << amount) | (word >> back);

endmodule

// File: rtl/rc5_encryptor.sv
// Iterative RC5 encryptor: one half-round per cycle, S table read through an external port.
module rc5_encryptor
    import rc5_pkg::*;
#(
    parameter int W = RC5_W,
    parameter int R = RC5_R,
    localparam int T        = 2 * (R + 1),
    localparam int T_LENGTH = $clog2(T),
    localparam int W_BITS   = $clog2(W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iKeyReady,
    input  logic                iStart,
    input  logic [W-1:0]        iA,
    input  logic [W-1:0]        iB,
    output logic [T_LENGTH-1:0] oS_address,
    input  logic [W-1:0]        iS_sub_i,
    output logic                oBusy,
    output logic [W-1:0]        oA,
    output logic [W-1:0]        oB,
    output logic                oDone
);

    localparam int RW = $clog2(R + 1);

    rc5_state_t    state;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  rot_a;
    logic [W-1:0]  rot_b;
    logic [W-1:0]  add_op;
    logic [W-1:0]  sum;
    logic [RW-1:0] round;
    logic [RW-1:0] round_next;

    assign round_next = round + RW'(1);

    rc5_rotl #(.W(W), .W_BITS(W_BITS)) u_rotl_a (
        .word    (a ^ b),
        .amount  (b[W_BITS-1:0]),
        .rotated (rot_a)
    );

    // rot_b sees the A written at the end of RND_A
    rc5_rotl #(.W(W), .W_BITS(W_BITS)) u_rotl_b (
        .word    (b ^ a),
        .amount  (a[W_BITS-1:0]),
        .rotated (rot_b)
    );

    // Operand select for the single shared adder
    always_comb begin
        add_op = '0;
        case (state)
            PRE_A:   add_op = a;
            PRE_B:   add_op = b;
            RND_A:   add_op = rot_a;
            RND_B:   add_op = rot_b;
            default: add_op = '0;
        endcase
    end

    assign sum = add_op + iS_sub_i;

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            round      <= '0;
            a          <= '0;
            b          <= '0;
            oA         <= '0;
            oB         <= '0;
            oDone      <= 1'b0;
            oBusy      <= 1'b0;
            oS_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart && iKeyReady) begin
                        a          <= iA;
                        b          <= iB;
                        round      <= RW'(1);
                        oBusy      <= 1'b1;
                        oS_address <= '0;
                        state      <= PRE_A;
                    end
                end
                PRE_A: begin
                    a          <= sum;
                    oS_address <= T_LENGTH'(1);
                    state      <= PRE_B;
                end
                PRE_B: begin
                    b          <= sum;
                    oS_address <= T_LENGTH'({round, 1'b0});
                    state      <= RND_A;
                end
                RND_A: begin
                    a          <= sum;
                    oS_address <= T_LENGTH'({round, 1'b1});
                    state      <= RND_B;
                end
                RND_B: begin
                    b <= sum;
                    if (round == RW'(R)) begin
                        // A is already final; B's final value is this cycle's sum
                        oA         <= a;
                        oB         <= sum;
                        oDone      <= 1'b1;
                        oBusy      <= 1'b0;
                        oS_address <= '0;
                        state      <= DONE;
                    end else begin
                        round      <= round_next;
                        oS_address <= T_LENGTH'({round_next, 1'b0});
                        state      <= RND_A;
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    oDone      <= 1'b0;
                    oBusy      <= 1'b0;
                    oS_address <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
